// File: rtl/wb_pkg.sv
// Shared encodings for the write-back stage: result-source select and load funct3 codes.
package wb_pkg;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10,
        RES_RSVD = 2'b11
    } result_src_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/writeback_pipe_if.sv
// M-stage inputs and W-stage outputs of the write-back pipe, bundled as one interface.
interface writeback_pipe_if #(
    parameter int D_WIDTH   = 32,
    parameter int A_WIDTH   = 5,
    parameter int CNT_WIDTH = 32
);
    logic                 ValidM;
    logic                 RegWriteM;
    logic [1:0]           ResultSrcM;
    logic [2:0]           Funct3M;
    logic [A_WIDTH-1:0]   RdM;
    logic [D_WIDTH-1:0]   ALUResultM;
    logic [D_WIDTH-1:0]   ReadDataM;
    logic [D_WIDTH-1:0]   PCPlus4M;

    logic                 RegWriteW;
    logic [A_WIDTH-1:0]   RdW;
    logic [D_WIDTH-1:0]   ResultW;
    logic                 ValidW;
    logic [CNT_WIDTH-1:0] RetireCount;

    modport master (
        output ValidM, RegWriteM, ResultSrcM, Funct3M, RdM, ALUResultM, ReadDataM, PCPlus4M,
        input  RegWriteW, RdW, ResultW, ValidW, RetireCount
    );

    modport slave (
        input  ValidM, RegWriteM, ResultSrcM, Funct3M, RdM, ALUResultM, ReadDataM, PCPlus4M,
        output RegWriteW, RdW, ResultW, ValidW, RetireCount
    );
endinterface

// File: rtl/load_extend.sv
// Load-data extraction: picks byte/half/word from the aligned memory word and extends to D_WIDTH.
module load_extend
    import wb_pkg::*;
#(
    parameter int D_WIDTH = 32
) (
    input  logic [D_WIDTH-1:0] word,
    input  logic [1:0]         offset,
    input  logic [2:0]         funct3,
    output logic [D_WIDTH-1:0] data
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (offset)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        // offset[0] is deliberately ignored for halfwords
        half_sel = offset[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        data = word;
        case (funct3)
            F3_LB:   data = {{(D_WIDTH-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {{(D_WIDTH-8){1'b0}}, byte_sel};
            F3_LH:   data = {{(D_WIDTH-16){half_sel[15]}}, half_sel};
            F3_LHU:  data = {{(D_WIDTH-16){1'b0}}, half_sel};
            default: data = word;
        endcase
    end
endmodule

// File: rtl/writeback_pipe.sv
// W-stage pipeline register with stall/flush, result selection and a retired-instruction counter.
module writeback_pipe
    import wb_pkg::*;
#(
    parameter int D_WIDTH   = 32,
    parameter int A_WIDTH   = 5,
    parameter int CNT_WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             flush_i,
    writeback_pipe_if.slave  bus
);
    logic                 valid_q;
    logic                 regwrite_q;
    logic [A_WIDTH-1:0]   rd_q;
    result_src_e          src_q;
    logic [2:0]           f3_q;
    logic [D_WIDTH-1:0]   alu_q;
    logic [D_WIDTH-1:0]   rdata_q;
    logic [D_WIDTH-1:0]   pc4_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic [D_WIDTH-1:0]   load_data;
    logic [D_WIDTH-1:0]   result_d;

    // The outgoing W instruction retires whenever the stage advances, even if a flush follows it.
    assign cnt_d = (valid_q && en_i) ? cnt_q + CNT_WIDTH'(1) : cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            src_q      <= RES_ALU;
            f3_q       <= '0;
            alu_q      <= '0;
            rdata_q    <= '0;
            pc4_q      <= '0;
            cnt_q      <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (flush_i) begin
                valid_q    <= 1'b0;
                regwrite_q <= 1'b0;
                rd_q       <= '0;
                src_q      <= RES_ALU;
                f3_q       <= '0;
                alu_q      <= '0;
                rdata_q    <= '0;
                pc4_q      <= '0;
            end else if (en_i) begin
                valid_q    <= bus.ValidM;
                regwrite_q <= bus.RegWriteM;
                rd_q       <= bus.RdM;
                src_q      <= result_src_e'(bus.ResultSrcM);
                f3_q       <= bus.Funct3M;
                alu_q      <= bus.ALUResultM;
                rdata_q    <= bus.ReadDataM;
                pc4_q      <= bus.PCPlus4M;
            end
        end
    end

    load_extend #(.D_WIDTH(D_WIDTH)) u_load_extend (
        .word   (rdata_q),
        .offset (alu_q[1:0]),
        .funct3 (f3_q),
        .data   (load_data)
    );

    always_comb begin
        result_d = '0;
        case (src_q)
            RES_ALU:  result_d = alu_q;
            RES_LOAD: result_d = load_data;
            RES_PC4:  result_d = pc4_q;
            default:  result_d = '0;
        endcase
    end

    assign bus.ValidW      = valid_q;
    assign bus.RdW         = rd_q;
    assign bus.RegWriteW   = regwrite_q && valid_q && (rd_q != '0);
    assign bus.ResultW     = result_d;
    assign bus.RetireCount = cnt_q;
endmodule

// File: doc/writeback_pipe.md
WRITEBACK_PIPE -- requirements
Module: writeback_pipe

Interface
REQ-001 SHALL have parameter D_WIDTH, default 32, datapath width; multiple of 16 and at least 32.
REQ-002 SHALL have parameter A_WIDTH, default 5, register-address width.
REQ-003 SHALL have parameter CNT_WIDTH, default 32, retire-counter width.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port en_i  input  1  stage advance; 0 = hold (stall).
REQ-007 SHALL have port flush_i  input  1  insert bubble instead of capturing the M-stage inputs.
REQ-008 SHALL have port ValidM  input  1  M-stage instruction is real, not a bubble.
REQ-009 SHALL have port RegWriteM  input  1  M-stage register-write request.
REQ-010 SHALL have port ResultSrcM  input  2  result select: 00 ALU, 01 load, 10 PC+4, 11 reserved.
REQ-011 SHALL have port Funct3M  input  3  load type.
REQ-012 SHALL have port RdM  input  A_WIDTH  destination register.
REQ-013 SHALL have ports ALUResultM, ReadDataM, PCPlus4M  input  D_WIDTH  each  candidate results; ReadDataM is the raw aligned memory word.
REQ-014 SHALL have port RegWriteW  output  1  register-file write enable.
REQ-015 SHALL have port RdW  output  A_WIDTH  register-file write address.
REQ-016 SHALL have port ResultW  output  D_WIDTH  write-back data and forwarding source.
REQ-017 SHALL have port ValidW  output  1  W-stage holds a real instruction.
REQ-018 SHALL have port RetireCount  output  CNT_WIDTH  count of retired instructions.

Function
REQ-019 SHALL register all M-stage inputs into the W stage on a rising edge with en_i=1; latency exactly 1 cycle.
REQ-020 SHALL hold all W-stage state unchanged on edges with en_i=0 and flush_i=0.
REQ-021 SHALL, on any edge with flush_i=1 (priority over en_i), load a bubble: ValidW=0, RegWriteW=0, RdW=0, and the stored data fields set to 0.
REQ-022 SHALL drive RegWriteW = stored RegWrite AND ValidW AND (RdW != 0); writes to x0 are never asserted.
REQ-023 SHALL select ResultW combinationally from stored fields: 00 ALU result, 01 extended load data, 10 PC+4, 11 all-zeros.
REQ-024 SHALL extract load data using byte offset = stored ALU result [1:0].
  - LB (000) and LBU (100): select byte [offset]; sign- or zero-extend.
  - LH (001) and LHU (101): offset[1] selects the half; offset[0] is ignored; sign- or zero-extend.
  - LW (010) and all other codes: full word, unmodified.
REQ-025 SHALL replicate the 32-bit extraction result, sign- or zero-extended, to D_WIDTH when D_WIDTH > 32.
REQ-026 SHALL increment RetireCount on each edge where ValidW=1 and en_i=1, independent of flush_i and of RegWrite; the counter wraps modulo 2^CNT_WIDTH with no saturation.
REQ-027 SHALL, when flush_i=1 and en_i=1 on the same edge, count the outgoing valid W instruction and capture a bubble.

Reset
REQ-028 SHALL, on an edge with rst=1 and regardless of en_i or flush_i, set ValidW=0, RegWriteW=0, RdW=0, all stored data fields to 0, and RetireCount=0; ResultW therefore reads 0.
REQ-029 SHALL discard any in-flight W instruction when reset is applied mid-operation, without counting it.

Structure
REQ-030 SHALL place the result-source encoding (enum) and the load funct3 constants in shared package wb_pkg.
REQ-031 SHALL implement extraction in one combinational sub-module, load_extend (inputs: word, offset, funct3; output: D_WIDTH data).

Verification
REQ-032 Load byte: ALUResultM=0x1002, ReadDataM=0x80FF7F01, Funct3M=000, ResultSrcM=01, RdM=5, en=1 -> next cycle ResultW=0xFFFFFFFF (byte 0xFF), RdW=5, RegWriteW=1.
REQ-033 Load halfword: same word, offset 2, Funct3M=101 -> ResultW=0x000080FF; Funct3M=001 -> ResultW=0xFFFF80FF.
REQ-034 x0 and reserved select: RdM=0 with RegWriteM=1 -> RegWriteW=0; ResultSrcM=11 -> ResultW=0.
REQ-035 Stall, flush and counting: capture a valid instruction, then en=0 for 3 cycles -> outputs held and RetireCount unchanged; then flush=1, en=1 -> RetireCount +1, ValidW=0.
REQ-036 Wrap: CNT_WIDTH=4, retire 17 valid instructions -> RetireCount=1.
REQ-037 Reset mid-stream: rst=1 while ValidW=1 -> next cycle ValidW=0, RetireCount=0, ResultW=0.
